// File: rtl/mdio_regs_pkg.sv
// rtl/mdio_regs_pkg.sv - Shared register map, bit indices and frame-state encoding for mdio_regs
package mdio_regs_pkg;

  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;
  localparam logic [4:0] REG_VCR  = 5'd16;

  localparam int BMCR_RESET    = 15;
  localparam int BMCR_LOOPBACK = 14;
  localparam int BMCR_SPEED    = 13;
  localparam int BMCR_DUPLEX   = 8;
  localparam int BMCR_COLTEST  = 7;

  localparam int BMSR_100FD  = 14;
  localparam int BMSR_100HD  = 13;
  localparam int BMSR_LINK   = 2;
  localparam int BMSR_EXTCAP = 0;

  localparam int VCR_LMTM   = 0;
  localparam int VCR_DTM    = 1;
  localparam int VCR_LOCKED = 8;

  localparam logic [5:0] PREAMBLE_LEN = 6'd32;
  localparam logic [1:0] OP_READ      = 2'b10;
  localparam logic [1:0] OP_WRITE     = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } frame_state_t;

endpackage

// File: rtl/mdio_regs_if.sv
// rtl/mdio_regs_if.sv - MDIO pad bundle between station management and the PHY slave
interface mdio_regs_if;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;

  modport master (output mdc, output mdio_i, input mdio_o, input mdio_oe);
  modport slave  (input mdc, input mdio_i, output mdio_o, output mdio_oe);
endinterface

// File: rtl/mdio_sync.sv
// rtl/mdio_sync.sv - 2-flop synchronizers for MDC/MDIO and registered MDC rising-edge strobe
module mdio_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio
);

  logic [1:0] mdc_ff;
  logic [1:0] mdio_ff;
  logic       mdc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_ff   <= 2'b00;
      mdio_ff  <= 2'b11;
      mdc_d    <= 1'b0;
      mdc_rise <= 1'b0;
    end else begin
      mdc_ff   <= {mdc_ff[0], mdc};
      mdio_ff  <= {mdio_ff[0], mdio_i};
      mdc_d    <= mdc_ff[1];
      mdc_rise <= mdc_ff[1] & ~mdc_d;
    end
  end

  assign mdio = mdio_ff[1];

endmodule

// File: rtl/mdio_regs.sv
// rtl/mdio_regs.sv - Clause 22 MDIO slave with BMCR/BMSR/ID1/ID2 and optional VCR (PHY_TEST_REGS_EN)
module mdio_regs
  import mdio_regs_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd0,
  parameter logic [21:0] OUI      = 22'h0,
  parameter logic [5:0]  MODEL    = 6'h0,
  parameter logic [3:0]  REVISION = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  mdio_regs_if.slave mif,
  input  logic       link_status,
  input  logic       locked,
  output logic       loopback,
  output logic       coltest,
  output logic       link_monitor_test_mode,
  output logic       descrambler_test_mode
);

`ifdef PHY_TEST_REGS_EN
  localparam bit TEST_REGS_EN = 1'b1;
`else
  localparam bit TEST_REGS_EN = 1'b0;
`endif

  logic mdc_rise;
  logic mdio_s;

  mdio_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .mdc      (mif.mdc),
    .mdio_i   (mif.mdio_i),
    .mdc_rise (mdc_rise),
    .mdio     (mdio_s)
  );

  frame_state_t state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        drop_q, drop_d;
  logic        is_read_q, is_read_d;
  logic        op_q, op_d;
  logic [3:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic        latch_rd, ta_drive, rd_step, rd_end, wr_shift, wr_commit;

  logic [15:0] shreg_q;
  logic [15:0] rd_data;
  logic        mdio_o_q, mdio_oe_q;
  logic        loopback_q, coltest_q, link_lat_q;
  logic [1:0]  vcr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      bit_cnt_q <= '0;
      drop_q    <= 1'b0;
      is_read_q <= 1'b0;
      op_q      <= 1'b0;
      phyad_q   <= '0;
      regad_q   <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      drop_q    <= drop_d;
      is_read_q <= is_read_d;
      op_q      <= op_d;
      phyad_q   <= phyad_d;
      regad_q   <= regad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    drop_d    = drop_q;
    is_read_d = is_read_q;
    op_d      = op_q;
    phyad_d   = phyad_q;
    regad_d   = regad_q;
    latch_rd  = 1'b0;
    ta_drive  = 1'b0;
    rd_step   = 1'b0;
    rd_end    = 1'b0;
    wr_shift  = 1'b0;
    wr_commit = 1'b0;
    if (mdc_rise) begin
      case (state_q)
        S_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q != PREAMBLE_LEN) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            if (pre_cnt_q == PREAMBLE_LEN) state_d = S_ST;
            pre_cnt_d = '0;
          end
        end
        S_ST: begin
          state_d   = mdio_s ? S_OP : S_IDLE;
          bit_cnt_d = '0;
          drop_d    = 1'b0;
        end
        S_OP: begin
          op_d      = mdio_s;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd1) begin
            state_d   = S_PHYAD;
            bit_cnt_d = '0;
            is_read_d = ({op_q, mdio_s} == OP_READ);
            if ({op_q, mdio_s} != OP_READ && {op_q, mdio_s} != OP_WRITE) drop_d = 1'b1;
          end
        end
        S_PHYAD: begin
          phyad_d   = {phyad_q[2:0], mdio_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd4) begin
            state_d   = S_REGAD;
            bit_cnt_d = '0;
            if ({phyad_q, mdio_s} != PHY_ADDR) drop_d = 1'b1;
          end
        end
        S_REGAD: begin
          regad_d   = {regad_q[3:0], mdio_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd4) begin
            state_d   = S_TA;
            bit_cnt_d = '0;
            latch_rd  = is_read_q && !drop_q;
          end
        end
        S_TA: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            ta_drive = is_read_q && !drop_q;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            rd_step   = is_read_q && !drop_q;
          end
        end
        S_DATA: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          wr_shift  = !is_read_q;
          if (bit_cnt_q == 4'd15) begin
            state_d   = S_IDLE;
            pre_cnt_d = '0;
            bit_cnt_d = '0;
            rd_end    = is_read_q && !drop_q;
            wr_commit = !is_read_q && !drop_q;
          end else begin
            rd_step = is_read_q && !drop_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Address is taken from regad_d so the register is latched on the same rise that completes REGAD.
  always_comb begin
    rd_data = '0;
    case (regad_d)
      REG_BMCR: begin
        rd_data[BMCR_LOOPBACK] = loopback_q;
        rd_data[BMCR_SPEED]    = 1'b1;
        rd_data[BMCR_DUPLEX]   = 1'b1;
        rd_data[BMCR_COLTEST]  = coltest_q;
      end
      REG_BMSR: begin
        rd_data[BMSR_100FD]  = 1'b1;
        rd_data[BMSR_100HD]  = 1'b1;
        rd_data[BMSR_LINK]   = link_lat_q;
        rd_data[BMSR_EXTCAP] = 1'b1;
      end
      REG_ID1: rd_data = OUI[21:6];
      REG_ID2: rd_data = {OUI[5:0], MODEL, REVISION};
      REG_VCR: begin
        if (TEST_REGS_EN) begin
          rd_data[VCR_LMTM]   = vcr_q[VCR_LMTM];
          rd_data[VCR_DTM]    = vcr_q[VCR_DTM];
          rd_data[VCR_LOCKED] = locked;
        end
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
    end else begin
      if (latch_rd)      shreg_q <= rd_data;
      else if (rd_step)  shreg_q <= {shreg_q[14:0], 1'b0};
      else if (wr_shift) shreg_q <= {shreg_q[14:0], mdio_s};
      if (ta_drive) begin
        mdio_oe_q <= 1'b1;
        mdio_o_q  <= 1'b0;
      end else if (rd_step) begin
        mdio_o_q  <= shreg_q[15];
      end else if (rd_end) begin
        mdio_oe_q <= 1'b0;
        mdio_o_q  <= 1'b1;
      end
    end
  end

  // On commit the written word is {shreg_q[14:0], mdio_s}: bit n lives in shreg_q[n-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loopback_q <= 1'b0;
      coltest_q  <= 1'b0;
      link_lat_q <= 1'b0;
      vcr_q      <= '0;
    end else begin
      if (wr_commit && regad_q == REG_BMCR) begin
        if (shreg_q[BMCR_RESET-1]) begin
          loopback_q <= 1'b0;
          coltest_q  <= 1'b0;
        end else begin
          loopback_q <= shreg_q[BMCR_LOOPBACK-1];
          coltest_q  <= shreg_q[BMCR_COLTEST-1];
        end
      end
      if (TEST_REGS_EN && wr_commit && regad_q == REG_VCR) begin
        vcr_q[VCR_LMTM] <= mdio_s;
        vcr_q[VCR_DTM]  <= shreg_q[VCR_DTM-1];
      end
      if (!link_status)                         link_lat_q <= 1'b0;
      else if (rd_end && regad_q == REG_BMSR)   link_lat_q <= 1'b1;
    end
  end

  assign mif.mdio_o             = mdio_o_q;
  assign mif.mdio_oe            = mdio_oe_q;
  assign loopback               = loopback_q;
  assign coltest                = coltest_q;
  assign link_monitor_test_mode = vcr_q[VCR_LMTM];
  assign descrambler_test_mode  = vcr_q[VCR_DTM];

endmodule

// File: tb/tb_mdio_regs.sv
// tb/tb_mdio_regs.sv - Directed self-checking bench for mdio_regs (honours PHY_TEST_REGS_EN)
module tb_mdio_regs;

`ifdef PHY_TEST_REGS_EN
  localparam bit TEST_EN = 1'b1;
`else
  localparam bit TEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic link_status;
  logic locked;
  logic loopback, coltest, lmtm, dtm;

  mdio_regs_if mif();

  mdio_regs #(
    .PHY_ADDR (5'h05),
    .OUI      (22'h2b5a3c),
    .MODEL    (6'h15),
    .REVISION (4'h7)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .mif                    (mif.slave),
    .link_status            (link_status),
    .locked                 (locked),
    .loopback               (loopback),
    .coltest                (coltest),
    .link_monitor_test_mode (lmtm),
    .descrambler_test_mode  (dtm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rdata;
  logic [1:0]  ta_oe;
  logic [1:0]  ta_o;
  logic        oe_any;
  logic        oe_data_all;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MDC period: drive during low phase, sample pad just before the rising edge.
  task automatic mdc_cycle(input logic d, output logic q, output logic oe);
    mif.mdio_i = d;
    #80;
    q  = mif.mdio_o;
    oe = mif.mdio_oe;
    mif.mdc = 1'b1;
    #80;
    mif.mdc = 1'b0;
  endtask

  task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phyad,
                       input logic [4:0] regad, input logic [15:0] wdata, input int n_data);
    logic q, oe;
    logic [13:0] hdr;
    hdr = {2'b01, op, phyad, regad};
    oe_any = 1'b0;
    oe_data_all = 1'b1;
    rdata = '0;
    for (int i = 0; i < pre_len; i++) begin
      mdc_cycle(1'b1, q, oe);
      oe_any |= oe;
    end
    for (int i = 13; i >= 0; i--) begin
      mdc_cycle(hdr[i], q, oe);
      oe_any |= oe;
    end
    for (int i = 0; i < 2; i++) begin
      mdc_cycle((op == 2'b01) ? (i == 0) : 1'b1, q, oe);
      ta_oe[i] = oe;
      ta_o[i]  = q;
      oe_any  |= oe;
    end
    for (int i = 15; i >= 16 - n_data; i--) begin
      mdc_cycle((op == 2'b01) ? wdata[i] : 1'b1, q, oe);
      rdata[i] = q;
      oe_data_all &= oe;
      oe_any |= oe;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    link_status = 1'b1;
    locked      = 1'b1;
    mif.mdc     = 1'b0;
    mif.mdio_i  = 1'b1;
    #22;
    check("reset_oe", mif.mdio_oe, 0);
    check("reset_o", mif.mdio_o, 1);
    check("reset_loopback", loopback, 0);
    check("reset_coltest", coltest, 0);
    check("reset_lmtm", lmtm, 0);
    check("reset_dtm", dtm, 0);
    rst_n = 1'b1;
    #40;

    frame(32, 2'b10, 5'h05, 5'd2, 16'h0, 16);
    check("id1_data", rdata, 16'hAD68);
    check("id1_ta_oe", ta_oe, 2'b10);
    check("id1_ta2_o", ta_o[1], 0);
    check("id1_oe_data", oe_data_all, 1);
    check("id1_oe_end", mif.mdio_oe, 0);

    frame(32, 2'b10, 5'h05, 5'd3, 16'h0, 16);
    check("id2_data", rdata, 16'hF157);

    frame(32, 2'b01, 5'h05, 5'd0, 16'h4080, 16);
    check("bmcr_wr_loopback", loopback, 1);
    check("bmcr_wr_coltest", coltest, 1);
    frame(32, 2'b10, 5'h05, 5'd0, 16'h0, 16);
    check("bmcr_rd", rdata, 16'h6180);

    @(negedge clk) link_status = 1'b0;
    @(negedge clk) link_status = 1'b1;
    #2;
    frame(32, 2'b10, 5'h05, 5'd1, 16'h0, 16);
    check("bmsr_rd1", rdata, 16'h6001);
    frame(32, 2'b10, 5'h05, 5'd1, 16'h0, 16);
    check("bmsr_rd2", rdata, 16'h6005);

    frame(31, 2'b01, 5'h05, 5'd0, 16'h0000, 16);
    check("short_pre_oe", oe_any, 0);
    check("short_pre_loopback", loopback, 1);
    frame(32, 2'b10, 5'h06, 5'd2, 16'h0, 16);
    check("wrong_phy_rd_oe", oe_any, 0);
    frame(32, 2'b01, 5'h06, 5'd0, 16'h0000, 16);
    check("wrong_phy_wr_oe", oe_any, 0);
    check("wrong_phy_wr_loopback", loopback, 1);
    frame(32, 2'b10, 5'h05, 5'd0, 16'h0, 16);
    check("bmcr_after_drops", rdata, 16'h6180);

    frame(32, 2'b01, 5'h05, 5'd0, 16'h8000, 16);
    check("bmcr_rst_loopback", loopback, 0);
    check("bmcr_rst_coltest", coltest, 0);
    frame(32, 2'b10, 5'h05, 5'd0, 16'h0, 16);
    check("bmcr_rst_rd", rdata, 16'h2100);

    frame(32, 2'b01, 5'h05, 5'd16, 16'h0003, 16);
    check("vcr_lmtm", lmtm, TEST_EN ? 1 : 0);
    check("vcr_dtm", dtm, TEST_EN ? 1 : 0);
    frame(32, 2'b10, 5'h05, 5'd16, 16'h0, 16);
    check("vcr_rd", rdata, TEST_EN ? 16'h0103 : 16'h0000);

    frame(32, 2'b01, 5'h05, 5'd0, 16'h4000, 16);
    check("pre_abort_loopback", loopback, 1);
    frame(32, 2'b10, 5'h05, 5'd2, 16'h0, 5);
    check("abort_oe_mid", mif.mdio_oe, 1);
    check("abort_partial", rdata[15:11], 5'b10101);
    rst_n = 1'b0;
    #1;
    check("abort_oe_now", mif.mdio_oe, 0);
    check("abort_loopback", loopback, 0);
    #20;
    rst_n = 1'b1;
    #40;
    frame(32, 2'b10, 5'h05, 5'd3, 16'h0, 16);
    check("post_abort_id2", rdata, 16'hF157);
    frame(32, 2'b10, 5'h05, 5'd0, 16'h0, 16);
    check("post_abort_bmcr", rdata, 16'h2100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
